vga_sink: RTL and testbench

Video-output sink that sits on the far end of the GPU's VGA interface (`vga_hs`, `vga_vs`, `vga_r/g/b`) in the `vga_clk` domain. It recovers raster timing from the sync pulses, locks to the expected 800x600@60 (40 MHz) format, and re-emits active pixels with x/y coordinates. It also counts timing errors and produces a per-frame checksum, so benches and on-board self-test can verify frames without dumping waveforms.

---
 rtl/vga_sink.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_sink.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sink.sv
// rtl/vga_sink.sv - VGA raster sink: sync recovery, lock, pixel re-emit, error count, frame checksum
//
// Purpose: sits on the far end of a VGA link in the pixel clock domain. It rebuilds
// raster position from the sync pulses and locks to the configured timing. While
// locked it re-emits active pixels with x/y coordinates, pulses frame_done at the
// end of every completed frame, and counts timing errors.
//
// Optional feature macro: VGA_SINK_CHECKSUM_EN
//    defined   - a per-frame checksum register is built and reported on frame_checksum
//    undefined - no checksum register is built; frame_checksum is tied to 0
//
// Ports:
//    vga_clk                  in   pixel clock (only clock)
//    reset                    in   synchronous, active-high
//    vga_hs, vga_vs           in   sync inputs, asserted level SYNC_POL
//    vga_r/g/b                in   colour inputs, COLOR_W bits each
//    pix_valid                out  active-region pixel present on pix_*
//    pix_x / pix_y            out  column / row of the pixel
//    pix_r/g/b                out  pixel colour (held while pix_valid = 0)
//    locked                   out  timing lock achieved
//    frame_done               out  one-cycle pulse after the last pixel of a locked frame
//    frame_count              out  completed locked frames, wraps
//    frame_checksum           out  checksum of the last completed frame
//    err_count                out  timing errors seen while locked, saturates at 255
module vga_sink #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 40,
   parameter int   H_SYNC   = 128,
   parameter int   H_BP     = 88,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 4,
   parameter int   V_BP     = 23,
   parameter logic SYNC_POL = 1'b1,
   parameter int   COLOR_W  = 4
) (
   input  logic               vga_clk,
   input  logic               reset,
   input  logic               vga_hs,
   input  logic               vga_vs,
   input  logic [COLOR_W-1:0] vga_r,
   input  logic [COLOR_W-1:0] vga_g,
   input  logic [COLOR_W-1:0] vga_b,
   output logic               pix_valid,
   output logic [10:0]        pix_x,
   output logic [9:0]         pix_y,
   output logic [COLOR_W-1:0] pix_r,
   output logic [COLOR_W-1:0] pix_g,
   output logic [COLOR_W-1:0] pix_b,
   output logic               locked,
   output logic               frame_done,
   output logic [15:0]        frame_count,
   output logic [31:0]        frame_checksum,
   output logic [7:0]         err_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SAT   = HW'(H_TOTAL);
   localparam logic [HW-1:0] H_FIRST = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_END   = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SAT   = VW'(V_TOTAL);
   localparam logic [VW-1:0] V_FIRST = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_END   = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {SEEK_H, SEEK_V, LOCKED} state_t;

   state_t state, state_nx;

   logic               hs_s1, vs_s1, hs_s2, vs_s2;
   logic [COLOR_W-1:0] r_s1, g_s1, b_s1;
   logic [HW-1:0]      h, h_now;
   logic [VW-1:0]      v, v_now;
   logic               vs_seen;
   logic               eof_pend;

   logic hs_edge, vs_edge, vs_tag;
   logic timing_err;
   logic pix_active;
   logic last_pix;
   logic frame_end;

   // Counters describe the sample currently in s1: h_now/v_now are its raster
   // position, h/v hold the position of the previous sample. Both saturate one
   // past their last legal value so a missing sync is reported exactly once and
   // never wraps back into the active window.
   always_comb begin
      state_nx   = state;
      hs_edge    = (hs_s1 == SYNC_POL) && (hs_s2 != SYNC_POL);
      vs_edge    = (vs_s1 == SYNC_POL) && (vs_s2 != SYNC_POL);
      vs_tag     = vs_seen || vs_edge;
      h_now      = h;
      v_now      = v;
      timing_err = 1'b0;
      pix_active = 1'b0;
      last_pix   = 1'b0;
      frame_end  = 1'b0;

      if (hs_edge) begin
         h_now = '0;
      end else if (h != H_SAT) begin
         h_now = h + 1'b1;
      end

      if (hs_edge) begin
         if (vs_tag) begin
            v_now = '0;
         end else if (v != V_SAT) begin
            v_now = v + 1'b1;
         end
      end

      if (state == LOCKED) begin
         timing_err = (hs_edge && (h != H_LAST))
                   || (!hs_edge && (h == H_LAST))
                   || (hs_edge && vs_tag && (v != V_LAST))
                   || (hs_edge && !vs_tag && (v == V_LAST));
         pix_active = (h_now >= H_FIRST) && (h_now <= H_END)
                   && (v_now >= V_FIRST) && (v_now <= V_END);
         last_pix   = (h_now == H_END) && (v_now == V_END);
         // An error on the cycle that would close the frame suppresses the close.
         frame_end  = eof_pend && !timing_err;
      end

      case (state)
         SEEK_H:  if (hs_edge) state_nx = SEEK_V;
         SEEK_V:  if (hs_edge && vs_tag) state_nx = LOCKED;
         LOCKED:  if (timing_err) state_nx = SEEK_H;
         default: state_nx = SEEK_H;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state       <= SEEK_H;
         hs_s1       <= !SYNC_POL;
         vs_s1       <= !SYNC_POL;
         hs_s2       <= !SYNC_POL;
         vs_s2       <= !SYNC_POL;
         r_s1        <= '0;
         g_s1        <= '0;
         b_s1        <= '0;
         h           <= '0;
         v           <= '0;
         vs_seen     <= 1'b0;
         eof_pend    <= 1'b0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_r       <= '0;
         pix_g       <= '0;
         pix_b       <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         err_count   <= '0;
      end else begin
         state <= state_nx;
         hs_s1 <= vga_hs;
         vs_s1 <= vga_vs;
         hs_s2 <= hs_s1;
         vs_s2 <= vs_s1;
         r_s1  <= vga_r;
         g_s1  <= vga_g;
         b_s1  <= vga_b;
         h     <= h_now;
         v     <= v_now;

         // A VS edge tags the next HS edge; a coincident edge is tagged directly.
         if (hs_edge) begin
            vs_seen <= 1'b0;
         end else if (vs_edge) begin
            vs_seen <= 1'b1;
         end

         pix_valid <= pix_active;
         if (pix_active) begin
            pix_x <= 11'(h_now - H_FIRST);
            pix_y <= 10'(v_now - V_FIRST);
            pix_r <= r_s1;
            pix_g <= g_s1;
            pix_b <= b_s1;
         end

         eof_pend   <= pix_active && last_pix;
         frame_done <= frame_end;
         if (frame_end) begin
            frame_count <= frame_count + 16'd1;
         end

         if (timing_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

   assign locked = (state == LOCKED);

`ifdef VGA_SINK_CHECKSUM_EN
   logic [31:0] csum, csum_base;

   // The frame-origin sample restarts the running checksum.
   always_comb begin
      csum_base = csum;
      if ((h_now == '0) && (v_now == '0)) begin
         csum_base = '0;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         csum           <= '0;
         frame_checksum <= '0;
      end else begin
         if (pix_active) begin
            csum <= {csum_base[30:0], csum_base[31]} ^ 32'({r_s1, g_s1, b_s1});
         end else begin
            csum <= csum_base;
         end
         if (frame_end) begin
            frame_checksum <= csum;
         end
      end
   end
`else
   assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_vga_sink.sv
// tb/tb_vga_sink.sv - scoreboard bench for vga_sink on a reduced raster
module tb_vga_sink;

   localparam int H_ACTIVE = 8;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 2;
   localparam int H_BP     = 2;
   localparam int V_ACTIVE = 4;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 1;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_FIRST  = H_SYNC + H_BP;
   localparam int V_FIRST  = V_SYNC + V_BP;
   localparam logic POL    = 1'b1;

   logic        vga_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        vga_hs  = !POL;
   logic        vga_vs  = !POL;
   logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
   logic        pix_valid;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic [3:0]  pix_r, pix_g, pix_b;
   logic        locked;
   logic        frame_done;
   logic [15:0] frame_count;
   logic [31:0] frame_checksum;
   logic [7:0]  err_count;

   vga_sink #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(POL), .COLOR_W(4)
   ) dut (
      .vga_clk(vga_clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .locked(locked), .frame_done(frame_done), .frame_count(frame_count),
      .frame_checksum(frame_checksum), .err_count(err_count)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
   } pix_t;

   typedef struct packed {
      logic [31:0] csum;
      logic [15:0] count;
   } done_t;

   pix_t  exp_pix[$];
   done_t exp_done[$];
   int    checks = 0;
   int    errors = 0;

   // Reference model: frame-level view of the sink.
   bit m_synced = 1'b0;   // line sync seen since the last disruption
   int m_err    = 0;
   int m_frames = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // kind: 0 clean, 1 line fline one cycle short, 2 HS missing on lines fline and fline+1,
   //       3 reset pulse on the first sample of line fline.
   // mode: 0 random colour, 1 colour = x[3:0] on all channels, 2 black.
   task automatic gen_frame(input int kind, input int fline, input int mode);
      bit          locked_f, faulted, hs_on, disrupt;
      int          len, x, y;
      logic [3:0]  r, g, b;
      logic [31:0] cs;
      pix_t        p;
      done_t       d;
      faulted  = 1'b0;
      cs       = '0;
      locked_f = m_synced;
      for (int ln = 0; ln < V_TOTAL; ln++) begin
         hs_on   = !(kind == 2 && (ln == fline || ln == fline + 1));
         disrupt = (kind == 1 && ln == fline + 1) || (kind >= 2 && ln == fline);
         len     = (kind == 1 && ln == fline) ? H_TOTAL - 1 : H_TOTAL;
         if (disrupt) begin
            if (kind == 3) begin
               m_err    = 0;
               m_frames = 0;
            end else if (locked_f && !faulted && m_err < 255) begin
               m_err++;
            end
            faulted  = 1'b1;
            m_synced = 1'b0;
         end else if (hs_on) begin
            m_synced = 1'b1;
         end
         for (int h = 0; h < len; h++) begin
            x = h - H_FIRST;
            y = ln - V_FIRST;
            {r, g, b} = 12'($urandom);
            if (mode == 1 && x >= 0 && x < H_ACTIVE) begin
               r = 4'(x);
               g = 4'(x);
               b = 4'(x);
            end else if (mode == 2) begin
               {r, g, b} = '0;
            end
            if (x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE && locked_f && !faulted) begin
               p.x = 11'(x);
               p.y = 10'(y);
               p.r = r;
               p.g = g;
               p.b = b;
               exp_pix.push_back(p);
               cs = {cs[30:0], cs[31]} ^ {20'd0, r, g, b};
               if (x == H_ACTIVE - 1 && y == V_ACTIVE - 1) begin
                  m_frames++;
`ifdef VGA_SINK_CHECKSUM_EN
                  d.csum = cs;
`else
                  d.csum = '0;
`endif
                  d.count = 16'(m_frames);
                  exp_done.push_back(d);
               end
            end
            if (ln == V_TOTAL - 1 && h == len - 1) begin
               check("frame_end_locked", 64'(locked), 64'(locked_f && !faulted));
               check("frame_end_err_count", 64'(err_count), 64'(m_err));
            end
            vga_hs = (hs_on && h < H_SYNC) ? POL : !POL;
            vga_vs = (ln < V_SYNC) ? POL : !POL;
            vga_r  = r;
            vga_g  = g;
            vga_b  = b;
            reset  = (kind == 3 && ln == fline && h == 0);
            @(posedge vga_clk);
            #1;
         end
      end
   endtask

   // Monitor: compares every presented pixel / frame_done against the scoreboard.
   pix_t        hold_pix = '0;
   bit          rst_d    = 1'b1;
   bit          pv_d     = 1'b0;
   logic [10:0] x_d      = '0;
   logic [9:0]  y_d      = '0;
   int          fcnt     = 0;

   always @(negedge vga_clk) begin
      pix_t  cur;
      pix_t  e;
      done_t d;
      cur = {pix_x, pix_y, pix_r, pix_g, pix_b};
      if (rst_d) begin
         check("reset_pix_valid", 64'(pix_valid), 64'(0));
         check("reset_pix_fields", 64'(cur), 64'(0));
         check("reset_locked", 64'(locked), 64'(0));
         check("reset_frame_done", 64'(frame_done), 64'(0));
         check("reset_frame_count", 64'(frame_count), 64'(0));
         check("reset_frame_checksum", 64'(frame_checksum), 64'(0));
         check("reset_err_count", 64'(err_count), 64'(0));
         hold_pix = '0;
      end
      if (pix_valid) begin
         if (exp_pix.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %0h expected none at %0t", cur, $time);
         end else begin
            e = exp_pix.pop_front();
            check("pixel", 64'(cur), 64'(e));
         end
         hold_pix = cur;
         fcnt = (pix_x == 11'd0 && pix_y == 10'd0) ? 1 : fcnt + 1;
      end else if (!rst_d) begin
         check("pix_hold", 64'(cur), 64'(hold_pix));
      end
      if (frame_done) begin
         check("done_after_last_pixel", 64'({pv_d, x_d, y_d}),
               64'({1'b1, 11'(H_ACTIVE - 1), 10'(V_ACTIVE - 1)}));
         check("pixels_per_frame", 64'(fcnt), 64'(H_ACTIVE * V_ACTIVE));
         if (exp_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got count %0d expected none at %0t", frame_count, $time);
         end else begin
            d = exp_done.pop_front();
            check("frame_checksum", 64'(frame_checksum), 64'(d.csum));
            check("frame_count", 64'(frame_count), 64'(d.count));
         end
      end
      pv_d  = pix_valid;
      x_d   = pix_x;
      y_d   = pix_y;
      rst_d = reset;
   end

   initial begin
      reset = 1'b1;
      repeat (4) begin
         @(posedge vga_clk);
         #1;
      end
      reset = 1'b0;
      gen_frame(0, 0, 0);          // acquisition frame, no output
      gen_frame(0, 0, 2);          // black
      gen_frame(0, 0, 1);          // x pattern
      gen_frame(0, 0, 0);
      gen_frame(1, 4, 0);          // short line
      gen_frame(0, 0, 1);          // relocked
      gen_frame(2, 3, 0);          // missing HS
      gen_frame(0, 0, 0);
      gen_frame(3, 4, 1);          // reset mid-frame
      gen_frame(0, 0, 1);
      gen_frame(0, 0, 0);
      for (int i = 0; i < 262; i++) begin
         gen_frame(2, 3, i % 3);
      end
      gen_frame(0, 0, 0);
      check("err_count_saturated", 64'(err_count), 64'(255));
      check("pixel_queue_drained", 64'(exp_pix.size()), 64'(0));
      check("done_queue_drained", 64'(exp_done.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
